// File: rtl/bin_to_bcd_converter.sv
// bin_to_bcd_converter
// Sequential double-dabble binary-to-BCD converter feeding the display mux.
// One add-3/shift iteration per clock; results land in registered outputs.
// Optional leading-zero blanking mask: define BIN_TO_BCD_BLANK_EN.
module bin_to_bcd_converter #(
  parameter int WIDTH  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Largest value representable in DIGITS decimal digits.
  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t          state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]   work;
  logic [CW-1:0]   cnt;
  logic            ovf_pend;

  logic [BW-1:0]     adj;
  logic [DIGITS-1:0] blank_next;
  logic [63:0]       bin64;

  assign bin64 = 64'(bin);

  // Add 3 to every working digit that is 5 or more, ahead of the shift.
  always_comb begin
    adj = work;
    for (int k = 0; k < DIGITS; k++) begin
      if (work[4*k +: 4] >= 4'd5) adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
    end
  end

`ifdef BIN_TO_BCD_BLANK_EN
  // Blank digit k when it and all higher digits are zero; units never blank.
  always_comb begin
    logic z;
    z = 1'b1;
    blank_next = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      z = z & (work[4*k +: 4] == 4'd0);
      blank_next[k] = z;
    end
  end
`else
  // Blanking not built: mask stays all zeros.
  always_comb begin
    blank_next = '0;
  end
`endif

  // Conversion FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      work     <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      blank    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= bin;
            work     <= '0;
            cnt      <= CW'(WIDTH);
            ovf_pend <= (bin64 > MAX_VAL);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Carry out of the top digit is dropped, giving bin mod 10^DIGITS.
          work  <= {adj[BW-2:0], shreg[WIDTH-1]};
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FINISH;
        end
        FINISH: begin
          bcd      <= work;
          overflow <= ovf_pend;
          blank    <= blank_next;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Testbench for bin_to_bcd_converter: arithmetic reference model checked
// every cycle, plus directed vectors with literal expected values.
module tb_bin_to_bcd_converter;
  localparam int WIDTH  = 27;
  localparam int DIGITS = 8;
  localparam int LAT    = WIDTH + 1;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [WIDTH-1:0]    bin   = '0;
  logic                busy, done, overflow;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   blank;

  bin_to_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock(clock), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow), .blank(blank)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] p10(input int n);
    logic [63:0] p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input logic [63:0] v);
    logic [4*DIGITS-1:0] r = '0;
    logic [63:0] x = v % p10(DIGITS);
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 64'd10);
      x = x / 64'd10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] to_blank(input logic [4*DIGITS-1:0] b);
    logic [DIGITS-1:0] m = '0;
`ifdef BIN_TO_BCD_BLANK_EN
    for (int k = 1; k < DIGITS; k++)
      m[k] = ((b >> (4*k)) == 0);
`endif
    return m;
  endfunction

  int                  m_cnt = 0;
  logic [63:0]         m_cap = '0;
  logic                e_busy = 0, e_done = 0, e_ovf = 0;
  logic [4*DIGITS-1:0] e_bcd = '0;
  logic [DIGITS-1:0]   e_blank = '0;
  bit                  armed = 0;

  // Model: a conversion started at edge N publishes results at edge N+LAT.
  always @(posedge clock) begin
    if (reset) begin
      m_cnt = 0; e_busy = 0; e_done = 0; e_ovf = 0; e_bcd = '0; e_blank = '0;
      armed = 1;
    end else begin
      e_done = 0;
      if (m_cnt == 0) begin
        if (start) begin
          m_cap  = 64'(bin);
          m_cnt  = LAT;
          e_busy = 1;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          e_bcd   = to_bcd(m_cap);
          e_ovf   = (m_cap > p10(DIGITS) - 64'd1);
          e_blank = to_blank(e_bcd);
          e_done  = 1;
          e_busy  = 0;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clock) begin
    if (armed) begin
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("bcd", 64'(bcd), 64'(e_bcd));
      chk("overflow", 64'(overflow), 64'(e_ovf));
      chk("blank", 64'(blank), 64'(e_blank));
    end
  end

  // ---------------- directed stimulus ----------------
  // Start a conversion, scramble bin after capture, wait for done, check latency.
  task automatic run_conv(input logic [WIDTH-1:0] v, input string name);
    int lat;
    start = 1'b1; bin = v;
    @(negedge clock);
    start = 1'b0; bin = WIDTH'($urandom);
    lat = 0;
    while (!done && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(LAT));
  endtask

  int dones, last, gap;
  logic [DIGITS-1:0] exp_bl;

  initial begin
    // Model self-pins.
    chk("model_12345", 64'(to_bcd(64'd12345)), 64'h12345);
    chk("model_mod", 64'(to_bcd(64'd100000123)), 64'h123);

    repeat (3) @(negedge clock);
    chk("rst_bcd", 64'(bcd), 64'h0);
    chk("rst_busy", 64'({busy, done, overflow}), 64'h0);
    chk("rst_blank", 64'(blank), 64'h0);
    reset = 1'b0;
    @(negedge clock);

    run_conv(0, "zero");
    chk("zero_bcd", 64'(bcd), 64'h0);
    chk("zero_ovf", 64'(overflow), 64'h0);
`ifdef BIN_TO_BCD_BLANK_EN
    exp_bl = 8'b1111_1110;
`else
    exp_bl = 8'h00;
`endif
    chk("zero_blank", 64'(blank), 64'(exp_bl));

    run_conv(12345, "typ");
    chk("typ_bcd", 64'(bcd), 64'h00012345);
`ifdef BIN_TO_BCD_BLANK_EN
    exp_bl = 8'b1110_0000;
`else
    exp_bl = 8'h00;
`endif
    chk("typ_blank", 64'(blank), 64'(exp_bl));

    run_conv(99_999_999, "max");
    chk("max_bcd", 64'(bcd), 64'h99999999);
    chk("max_ovf", 64'(overflow), 64'h0);
    run_conv(100_000_000, "ovf");
    chk("ovf_bcd", 64'(bcd), 64'h00000000);
    chk("ovf_ovf", 64'(overflow), 64'h1);
    run_conv(27'h7FFFFFF, "allones");
    chk("allones_bcd", 64'(bcd), 64'h34217727);

    // Busy rejection: re-pulses sampled at edges N+5 and N+28 are ignored.
    @(negedge clock);
    start = 1'b1; bin = 42;
    dones = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (done) dones++;
      start = (i == 5 || i == 28);
      bin = start ? 27'd7 : 27'd42;
    end
    chk("rej_dones", 64'(dones), 64'd1);
    chk("rej_bcd", 64'(bcd), 64'h42);
    run_conv(7, "seven");
    chk("seven_bcd", 64'(bcd), 64'h7);

    // Reset ten cycles into a conversion; no done afterwards.
    @(negedge clock);
    start = 1'b1; bin = 987654;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_outs", 64'({busy, done, overflow}), 64'h0);
    chk("mid_rst_bcd", 64'(bcd), 64'h0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) dones++;
    end
    chk("mid_rst_nodone", 64'(dones), 64'd0);
    run_conv(987654, "fresh");
    chk("fresh_bcd", 64'(bcd), 64'h00987654);

    // Back-to-back: start held high, bin incrementing every cycle.
    @(negedge clock);
    bin = 27'd500; start = 1'b1;
    dones = 0; last = -1;
    for (int i = 0; i < 29 * 5 + 5; i++) begin
      @(negedge clock);
      bin = bin + 27'd1;
      if (done) begin
        if (last >= 0) begin
          gap = i - last;
          chk("b2b_period", 64'(gap), 64'd29);
        end
        last = i;
        dones++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 64'(dones >= 4), 64'd1);
    repeat (35) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_converter.md
# bin_to_bcd_converter

Sequential double-dabble converter that turns an unsigned binary value into packed BCD digits for the seven-segment display stage. It sits directly upstream of the display multiplexer: a counter or other data source pulses `start` with a value, and the multiplexer consumes the registered `bcd` nibbles exactly as it consumes hex nibbles today. The display therefore shows decimal instead of hex. One shift-and-adjust iteration is performed per clock, so the datapath stays small.

## Interface
- `WIDTH`, 27: binary input width; legal range 4..32.
- `DIGITS`, 8: number of BCD digits produced; one per display digit.

- `clock`  in  1  system clock (27 MHz on board)
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request conversion of `bin`; sampled only in IDLE
- `bin`  in  WIDTH  unsigned value; captured on the accepted `start` edge
- `busy`  out  1  high while a conversion is in progress
- `done`  out  1  one-cycle pulse when `bcd` and `overflow` update
- `bcd`  out  4*DIGITS  packed result; digit 0 (units) in [3:0], digit k in [4k+3:4k]
- `overflow`  out  1  captured `bin` exceeds 10^DIGITS − 1
- `blank`  out  DIGITS  leading-zero mask, bit k = 1 means blank digit k (see Configuration)

## Operation
- **Reset values:** state IDLE; `busy`=0, `done`=0, `bcd`=0, `overflow`=0, `blank`=0; working registers cleared.
- **States:** IDLE, SHIFT, FINISH.
- **IDLE:**
  - `start`=1 captures `bin` into a WIDTH-bit shift register.
  - Clears the 4*DIGITS working BCD register.
  - Loads the iteration counter with WIDTH.
  - Computes overflow (`bin` > 10^DIGITS − 1, evaluated at ≥64-bit width) into a pending flag.
  - Next state SHIFT.
- **SHIFT, once per cycle:**
  - Every working digit ≥5 gets +3.
  - Then {working, shift} shifts left by 1, with the MSB of the shift register entering bit 0 of the working register.
  - The counter decrements.
  - When the counter reaches 1 on this iteration, the next state is FINISH.
- **FINISH:**
  - `bcd` ← working register; `overflow` ← pending flag; `blank` ← computed mask.
  - `done` asserts for exactly the following cycle.
  - Next state IDLE.
- **Width rule:** bits carried out of the top digit are discarded. On overflow, `bcd` = `bin` mod 10^DIGITS, which is still correct decimal.
- `busy` = 1 in SHIFT and FINISH, 0 in IDLE.
- **`start` while busy** (SHIFT or FINISH) is ignored; no queuing.
- **Output hold:** `bcd`, `overflow` and `blank` hold their last values between conversions. They change only at the FINISH edge or on reset.
- **`bin` changes after capture** have no effect on the current conversion.
- **Reset mid-conversion:** immediate return to IDLE with all outputs at reset values. No `done` is produced for the aborted conversion.

## Timing
- Define edge N as the edge where `start` is sampled in IDLE.
- `busy` = 1 from after edge N through edge N+WIDTH+1.
- The final SHIFT iteration happens at edge N+WIDTH.
- FINISH registers outputs at edge N+WIDTH+1. `done` = 1 in the cycle after that edge, and `busy` = 0 in that same cycle.
- Latency is WIDTH+1 cycles from the start edge to the results being visible (28 cycles at the default configuration).
- A new `start` can be accepted at edge N+WIDTH+2 at the earliest, which is the cycle in which `done` is high.
- Maximum throughput is one conversion per WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `BIN_TO_BCD_BLANK_EN`.
- **Defined:**
  - At FINISH, `blank[k]` = 1 when digit k and every digit above it are zero, for k ≥ 1.
  - `blank[0]` is always 0, so a value of 0 shows a single "0".
- **Undefined:** the blanking logic is not compiled in and `blank` is tied to all zeros. The port always exists.

## Test plan
Default parameters, WIDTH=27 and DIGITS=8, unless stated.
- **Zero:** `bin`=0, pulse `start`.
  - `done` is high exactly 28 cycles after the start edge.
  - `bcd`=0x00000000, `overflow`=0.
  - `blank`=8'b1111_1110 with the macro; 0 without it.
- **Typical value:** `bin`=12345.
  - `bcd`=0x00012345.
  - `blank`=8'b1110_0000 with the macro.
- **Upper boundary:** `bin`=99_999_999 gives `bcd`=0x99999999 and `overflow`=0. Then `bin`=100_000_000 gives `bcd`=0x00000000 and `overflow`=1.
- **Busy rejection:** `start` with `bin`=42; re-pulse `start` with `bin`=7 in cycles 5 and 28 after the start edge.
  - Exactly one `done` is produced, with `bcd`=0x00000042.
  - A subsequent `start` in IDLE converts 7.
- **Reset mid-conversion:** assert `reset` 10 cycles into a conversion of 987654.
  - Outputs are reset values the next cycle and no `done` follows.
  - A fresh conversion of 987654 gives 0x00987654.
- **Back-to-back:** hold `start`=1 continuously with `bin` incrementing each cycle.
  - `done` pulses every 29 cycles.
  - Each `bcd` equals the decimal of the `bin` value sampled on its accepting edge.
